// File: rtl/pc_unit_rv32i.sv
// -----------------------------------------------------------------------------
// pc_unit_rv32i
//   Program-counter unit for the RV32I datapath. It holds the PC register and
//   picks the next PC from: the trap vector, a redirect (branch/jump) target,
//   the held value (stall), or the sequential increment. It also flags
//   misaligned redirect targets, produces a fetch-valid strobe and counts PC
//   updates.
//
//   Optional feature macro: RVC_SUPPORT_EN
//     defined   : sequential step is 2 when half_step=1 (else 4); targets only
//                 need bit 0 clear.
//     undefined : half_step ignored, step fixed at 4; targets need [1:0]==0.
//
// Ports
//   clk         in   1      rising-edge clock
//   rst_n       in   1      asynchronous active-low reset
//   stall       in   1      hold PC (lower priority than redirect/trap)
//   redirect    in   1      taken branch/jump this cycle
//   target      in   XLEN   redirect destination
//   trap        in   1      trap request, highest priority
//   half_step   in   1      next sequential step is +2 (RVC builds only)
//   PCout       out  XLEN   current PC
//   PCoutPlus4  out  XLEN   PCout + step, combinational, wraps modulo 2^XLEN
//   pc_valid    out  1      PCout is a valid fetch address this cycle
//   misalign    out  1      one-cycle pulse: redirect target was rejected
//   adv_count   out  CNT_W  number of PC updates since reset (wraps)
// -----------------------------------------------------------------------------
module pc_unit_rv32i #(
   parameter int unsigned       XLEN         = 32,
   parameter logic [XLEN-1:0]   RESET_VECTOR = '0,
   parameter logic [XLEN-1:0]   TRAP_VECTOR  = XLEN'(32'h0000_0100),
   parameter int unsigned       CNT_W        = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             stall,
   input  logic             redirect,
   input  logic [XLEN-1:0]  target,
   input  logic             trap,
   input  logic             half_step,
   output logic [XLEN-1:0]  PCout,
   output logic [XLEN-1:0]  PCoutPlus4,
   output logic             pc_valid,
   output logic             misalign,
   output logic [CNT_W-1:0] adv_count
);

   // Low target bits that must be zero for a redirect to be accepted.
`ifdef RVC_SUPPORT_EN
   localparam logic [1:0] ALIGN_MASK = 2'b01;
`else
   localparam logic [1:0] ALIGN_MASK = 2'b11;
`endif

   // ST_LAUNCH: first edge after reset only raises pc_valid, the PC stays on
   // the reset vector so that address is fetched. ST_RUN: normal operation.
   typedef enum logic {
      ST_LAUNCH = 1'b0,
      ST_RUN    = 1'b1
   } state_t;

   state_t           state, state_next;
   logic [XLEN-1:0]  step;
   logic [XLEN-1:0]  pc_next;
   logic             valid_next;
   logic             misalign_next;
   logic [CNT_W-1:0] count_next;

   function automatic logic target_aligned(input logic [1:0] low_bits);
      return (low_bits & ALIGN_MASK) == 2'b00;
   endfunction

`ifdef RVC_SUPPORT_EN
   assign step = half_step ? XLEN'(2) : XLEN'(4);
`else
   logic unused_half_step;
   assign unused_half_step = half_step;
   assign step = XLEN'(4);
`endif

   assign PCoutPlus4 = PCout + step;

   // State register plus all registered outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= ST_LAUNCH;
         PCout     <= RESET_VECTOR;
         pc_valid  <= 1'b0;
         misalign  <= 1'b0;
         adv_count <= '0;
      end else begin
         state     <= state_next;
         PCout     <= pc_next;
         pc_valid  <= valid_next;
         misalign  <= misalign_next;
         adv_count <= count_next;
      end
   end

   // Next-PC selection: trap > redirect > stall > sequential.
   always_comb begin
      state_next    = state;
      pc_next       = PCout;
      valid_next    = pc_valid;
      misalign_next = 1'b0;
      count_next    = adv_count;

      if (trap) begin
         // Trap wins outright; the target is ignored so no misalign pulse.
         pc_next    = TRAP_VECTOR;
         valid_next = 1'b0;
         count_next = adv_count + CNT_W'(1);
         state_next = ST_RUN;
      end else if (redirect) begin
         if (target_aligned(target[1:0])) begin
            pc_next    = target;
            valid_next = 1'b0;
            count_next = adv_count + CNT_W'(1);
            state_next = ST_RUN;
         end else begin
            // Rejected target: PC, valid and count all keep their values.
            misalign_next = 1'b1;
         end
      end else if (stall) begin
         // Everything held, including a pending bubble.
         state_next = state;
      end else if (state == ST_LAUNCH) begin
         valid_next = 1'b1;
         state_next = ST_RUN;
      end else begin
         pc_next    = PCout + step;
         valid_next = 1'b1;
         count_next = adv_count + CNT_W'(1);
      end
   end

endmodule

// File: tb/tb_pc_unit_rv32i.sv
module tb_pc_unit_rv32i;

   localparam longint MOD   = 64'h1_0000_0000;
   localparam longint RST_V = 0;
   localparam longint TRP_V = 64'h100;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        stall, redirect, trap, half_step;
   logic [31:0] target;
   logic [31:0] PCout, PCoutPlus4, adv_count;
   logic        pc_valid, misalign;

   pc_unit_rv32i dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .stall      (stall),
      .redirect   (redirect),
      .target     (target),
      .trap       (trap),
      .half_step  (half_step),
      .PCout      (PCout),
      .PCoutPlus4 (PCoutPlus4),
      .pc_valid   (pc_valid),
      .misalign   (misalign),
      .adv_count  (adv_count)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] pc;
      logic [31:0] plus4;
      logic        valid;
      logic        mis;
      logic [31:0] cnt;
   } exp_t;

   exp_t sb[$];

   int pass_cnt  = 0;
   int total_cnt = 0;

   // Reference model: architectural view of the PC unit.
   longint m_pc;
   longint m_cnt;
   bit     m_valid;
   bit     m_mis;
   bit     m_fetched_reset;  // reset address has been presented once

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total_cnt++;
      if (act === exp) pass_cnt++;
      else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
   endtask

   function automatic longint step_of(input bit h);
`ifdef RVC_SUPPORT_EN
      return h ? 2 : 4;
`else
      return 4;
`endif
   endfunction

   function automatic bit accepts(input longint t);
`ifdef RVC_SUPPORT_EN
      return (t % 2) == 0;
`else
      return (t % 4) == 0;
`endif
   endfunction

   task automatic model_reset();
      m_pc = RST_V; m_cnt = 0; m_valid = 0; m_mis = 0; m_fetched_reset = 0;
   endtask

   task automatic model_edge(input bit t, input bit r, input longint tg, input bit s, input bit h);
      m_mis = 0;
      if (t) begin
         m_pc = TRP_V; m_valid = 0; m_cnt = (m_cnt + 1) % MOD; m_fetched_reset = 1;
      end else if (r && accepts(tg)) begin
         m_pc = tg; m_valid = 0; m_cnt = (m_cnt + 1) % MOD; m_fetched_reset = 1;
      end else if (r) begin
         m_mis = 1;
      end else if (!s) begin
         if (!m_fetched_reset) m_fetched_reset = 1;
         else begin
            m_pc  = (m_pc + step_of(h)) % MOD;
            m_cnt = (m_cnt + 1) % MOD;
         end
         m_valid = 1;
      end
   endtask

   // Called at a falling edge; returns at the next falling edge.
   task automatic drive(input bit t, input bit r, input logic [31:0] tg, input bit s, input bit h);
      exp_t e;
      trap = t; redirect = r; target = tg; stall = s; half_step = h;
      model_edge(t, r, longint'(tg), s, h);
      e.pc    = m_pc[31:0];
      e.plus4 = 32'((m_pc + step_of(h)) % MOD);
      e.valid = m_valid;
      e.mis   = m_mis;
      e.cnt   = m_cnt[31:0];
      sb.push_back(e);
      @(negedge clk);
   endtask

   task automatic free_run(input int n);
      for (int i = 0; i < n; i++) drive(0, 0, 32'h0, 0, 0);
   endtask

   // Monitor: after every rising edge compare against the oldest expectation.
   always @(posedge clk) begin
      exp_t e;
      #1;
      if (sb.size() > 0) begin
         e = sb.pop_front();
         check("pc",       PCout,            e.pc);
         check("plus4",    PCoutPlus4,       e.plus4);
         check("valid",    32'(pc_valid),    32'(e.valid));
         check("misalign", 32'(misalign),    32'(e.mis));
         check("count",    adv_count,        e.cnt);
      end
   end

   initial begin
      logic [31:0] cnt_before, pc_before, tg;
      bit t, r, s, h;
      rst_n = 1'b0; stall = 0; redirect = 0; trap = 0; half_step = 0; target = '0;
      model_reset();
      @(negedge clk); @(negedge clk);

      // Reset state
      check("rst_pc",    PCout,              32'h0);
      check("rst_valid", 32'(pc_valid),      32'h0);
      check("rst_count", adv_count,          32'h0);
      check("rst_mis",   32'(misalign),      32'h0);
      rst_n = 1'b1;

      // Launch: 0, 4, 8
      free_run(1);
      check("t1_pc0", PCout, 32'h0);
      check("t1_v0",  32'(pc_valid), 32'h1);
      free_run(2);
      check("t1_pc8",  PCout,     32'h8);
      check("t1_cnt2", adv_count, 32'h2);

      // Wrap
      drive(0, 1, 32'hFFFF_FFFC, 0, 0);
      check("t2_pc",    PCout,      32'hFFFF_FFFC);
      check("t2_plus4", PCoutPlus4, 32'h0);
      free_run(1);
      check("t2_wrap",  PCout,      32'h0);

      // Redirect then stall during the bubble
      free_run(4);
      check("t3_pc10", PCout, 32'h10);
      drive(0, 1, 32'h1234_5678, 0, 0);
      check("t3_tgt",  PCout, 32'h1234_5678);
      check("t3_bub",  32'(pc_valid), 32'h0);
      drive(0, 0, 32'h0, 1, 0);
      drive(0, 0, 32'h0, 1, 0);
      check("t3_hold", PCout, 32'h1234_5678);
      check("t3_hbub", 32'(pc_valid), 32'h0);
      free_run(1);
      check("t3_next", PCout, 32'h1234_567C);
      check("t3_vld",  32'(pc_valid), 32'h1);

      // Target 0x6
      pc_before  = PCout;
      cnt_before = adv_count;
      drive(0, 1, 32'h0000_0006, 0, 0);
`ifdef RVC_SUPPORT_EN
      check("t4_pc",  PCout,          32'h6);
      check("t4_mis", 32'(misalign),  32'h0);
`else
      check("t4_pc",  PCout,          pc_before);
      check("t4_mis", 32'(misalign),  32'h1);
      check("t4_cnt", adv_count,      cnt_before);
`endif
      free_run(1);
      check("t4_mis_off", 32'(misalign), 32'h0);

      // Priority: trap over redirect (misaligned target) and stall
      drive(1, 1, 32'h0000_0007, 1, 0);
      check("t5_pc",  PCout,         32'h100);
      check("t5_mis", 32'(misalign), 32'h0);

      // Async reset between edges at PC 0x40
      drive(0, 1, 32'h0000_003C, 0, 0);
      free_run(1);
      check("t6_pc40", PCout, 32'h40);
      #2;
      rst_n = 1'b0;
      #1;
      check("t6_pc",    PCout,         32'h0);
      check("t6_valid", 32'(pc_valid), 32'h0);
      check("t6_cnt",   adv_count,     32'h0);
      model_reset();
      @(negedge clk);
      rst_n = 1'b1;

      // Randomized traffic
      for (int i = 0; i < 400; i++) begin
         t  = ($urandom_range(15) == 0);
         r  = ($urandom_range(5) == 0);
         s  = ($urandom_range(3) == 0);
         h  = $urandom_range(1);
         tg = $urandom;
         if ($urandom_range(2) != 0) tg[1:0] = 2'b00;
         drive(t, r, tg, s, h);
      end
      free_run(2);

      check("sb_drained", 32'(sb.size()), 32'h0);
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

   // Global time limit.
   initial begin
      #200000;
      $display("FAIL timeout: got running expected finished");
      $fatal(1, "timeout");
   end

endmodule
